// File: rtl/pot_scan_ctrl_if.sv
// Bundle for the pot scanner: enable, A2D strt_cnv/cnv_cmplt handshake and published pot bus.
// Latency: none; this file only groups the signals.
// Backpressure: none; the A2D handshake allows one outstanding conversion and the pot bus is never stalled.
interface pot_scan_ctrl_if #(
   parameter int NUM_POTS = 6,
   parameter int RES_W    = 12
);
   logic                      en;
   logic                      strt_cnv;
   logic [2:0]                chnnl;
   logic                      cnv_cmplt;
   logic [RES_W-1:0]          res;
   logic [NUM_POTS*RES_W-1:0] pot_vals;
   logic [NUM_POTS-1:0]       pot_chg;
   logic                      scan_done;
   logic                      settled;
   logic                      a2d_err;

   // Scanner side
   modport master (
      input  en, cnv_cmplt, res,
      output strt_cnv, chnnl, pot_vals, pot_chg, scan_done, settled, a2d_err
   );

   // A2D / equalizer side
   modport slave (
      output en, cnv_cmplt, res,
      input  strt_cnv, chnnl, pot_vals, pot_chg, scan_done, settled, a2d_err
   );
endinterface

// File: rtl/pot_scan_ctrl.sv
// Round-robin slide-pot scanner: A2D handshake, IIR smoothing, hysteresis publish, settle and timeout flags.
// Latency: cnv_cmplt sampled at edge N, pot_vals/pot_chg at edge N+1, next strt_cnv cycle follows at N+2.
// Backpressure: none; one conversion in flight, en low lets it finish and then idles.
module pot_scan_ctrl #(
   parameter int NUM_POTS     = 6,
   parameter int CH_OFFSET    = 0,
   parameter int RES_W        = 12,
   parameter int AVG_SHIFT    = 2,
   parameter int HYST         = 8,
   parameter int SETTLE_SCANS = 4,
   parameter int TIMEOUT      = 4096
)(
   input  logic           clk,
   input  logic           rst,
   pot_scan_ctrl_if.master bus
);

   localparam int IDX_W = (NUM_POTS > 1) ? $clog2(NUM_POTS) : 1;
   localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int CNT_W = $clog2(SETTLE_SCANS + 1);

   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_POTS - 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(SETTLE_SCANS);
   localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(SETTLE_SCANS - 1);
   localparam logic [RES_W:0]   HYST_V   = (RES_W+1)'(HYST);
   localparam logic [RES_W-1:0] MAX_V    = '1;

   typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_UPDATE} state_t;

   state_t                    r_state;
   state_t                    w_next;
   logic                      w_timeout;
   logic [IDX_W-1:0]          r_idx;
   logic [TMR_W-1:0]          r_timer;
   logic [RES_W-1:0]          r_res;
   logic [RES_W-1:0]          r_filt [NUM_POTS];
   logic [NUM_POTS-1:0]       r_first;
   logic [NUM_POTS*RES_W-1:0] r_pot_vals;
   logic [NUM_POTS-1:0]       r_pot_chg;
   logic                      r_scan_done;
   logic                      r_settled;
   logic                      r_a2d_err;
   logic [CNT_W-1:0]          r_scan_cnt;

   logic [RES_W-1:0]          w_filt_cur;
   logic [RES_W-1:0]          w_pv_cur;
   logic signed [RES_W:0]     w_diff;
   logic signed [RES_W:0]     w_step;
   logic signed [RES_W:0]     w_sum;
   logic [RES_W-1:0]          w_filt_new;
   logic [RES_W-1:0]          w_gap;
   logic                      w_pub;
   logic                      w_last;

   // Next-state decode; a timeout retries the same pot rather than skipping it
   always_comb begin
      w_next    = r_state;
      w_timeout = 1'b0;
      case (r_state)
         S_IDLE:   if (bus.en) w_next = S_START;
         S_START:  w_next = S_WAIT;
         S_WAIT: begin
            if (bus.cnv_cmplt) begin
               w_next = S_UPDATE;
            end else if (r_timer == TMR_LAST) begin
               w_timeout = 1'b1;
               w_next    = S_START;
            end
         end
         S_UPDATE: w_next = bus.en ? S_START : S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // Conversion watchdog: cleared on each start, counts while waiting
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                    r_timer <= '0;
      else if (r_state == S_START) r_timer <= '0;
      else if (r_state == S_WAIT)  r_timer <= r_timer + 1'b1;
   end

   // Capture the A2D result on completion
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                    r_res <= '0;
      else if (r_state == S_WAIT && bus.cnv_cmplt) r_res <= bus.res;
   end

   // Smoother: filt += (res - filt) >>> AVG_SHIFT; floor rounding means a rising
   // input can stop a few LSBs short of its target, falling inputs reach it exactly
   always_comb begin
      w_filt_cur = r_filt[r_idx];
      w_pv_cur   = r_pot_vals[r_idx*RES_W +: RES_W];
      w_diff     = $signed({1'b0, r_res}) - $signed({1'b0, w_filt_cur});
      w_step     = w_diff >>> AVG_SHIFT;
      w_sum      = $signed({1'b0, w_filt_cur}) + w_step;
      w_filt_new = r_first[r_idx] ? r_res : RES_W'(w_sum);
      w_gap      = (w_filt_new >= w_pv_cur) ? (w_filt_new - w_pv_cur) : (w_pv_cur - w_filt_new);
      w_pub      = r_first[r_idx]
                 || ({1'b0, w_gap} >= HYST_V)
                 || (w_filt_new == '0   && w_pv_cur != '0)
                 || (w_filt_new == MAX_V && w_pv_cur != MAX_V);
      w_last     = (r_idx == IDX_LAST);
   end

   // Per-pot filter state, publish, and round-robin index
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_POTS; i++) r_filt[i] <= '0;
         r_first     <= '1;
         r_pot_vals  <= '0;
         r_pot_chg   <= '0;
         r_scan_done <= 1'b0;
         r_idx       <= '0;
      end else begin
         r_pot_chg   <= '0;
         r_scan_done <= 1'b0;
         if (r_state == S_UPDATE) begin
            r_filt[r_idx]  <= w_filt_new;
            r_first[r_idx] <= 1'b0;
            if (w_pub) begin
               r_pot_vals[r_idx*RES_W +: RES_W] <= w_filt_new;
               r_pot_chg <= NUM_POTS'(1) << r_idx;
            end
            if (w_last) begin
               r_idx       <= '0;
               r_scan_done <= 1'b1;
            end else begin
               r_idx <= r_idx + 1'b1;
            end
         end
      end
   end

   // Scan counter saturates; settled is sticky until reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_scan_cnt <= '0;
         r_settled  <= 1'b0;
      end else if (r_state == S_UPDATE && w_last) begin
         if (r_scan_cnt < CNT_SAT)  r_scan_cnt <= r_scan_cnt + 1'b1;
         if (r_scan_cnt >= CNT_PRE) r_settled  <= 1'b1;
      end
   end

   // Sticky A2D error flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst)            r_a2d_err <= 1'b0;
      else if (w_timeout) r_a2d_err <= 1'b1;
   end

   assign bus.strt_cnv  = (r_state == S_START);
   assign bus.chnnl     = 3'(CH_OFFSET) + 3'(r_idx);
   assign bus.pot_vals  = r_pot_vals;
   assign bus.pot_chg   = r_pot_chg;
   assign bus.scan_done = r_scan_done;
   assign bus.settled   = r_settled;
   assign bus.a2d_err   = r_a2d_err;

endmodule

// File: tb/tb_pot_scan_ctrl.sv
// Directed bench for pot_scan_ctrl with a reference model feeding an expected-result queue.
// Latency: checks pot bus at edge N+1 after cnv_cmplt and strt_cnv re-issue right after.
// Backpressure: bench plays the A2D, answering each strt_cnv after a chosen delay or not at all.
module tb_pot_scan_ctrl;
   localparam int NP     = 6;
   localparam int RW     = 12;
   localparam int SHIFT  = 2;
   localparam int HYST   = 8;
   localparam int SETTLE = 4;
   localparam int TMO    = 4096;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   pot_scan_ctrl_if #(.NUM_POTS(NP), .RES_W(RW)) bus ();
   pot_scan_ctrl_if #(.NUM_POTS(3),  .RES_W(RW)) bus2 ();

   pot_scan_ctrl #(.NUM_POTS(NP), .CH_OFFSET(0), .RES_W(RW), .AVG_SHIFT(SHIFT),
                   .HYST(HYST), .SETTLE_SCANS(SETTLE), .TIMEOUT(TMO))
      dut (.clk(clk), .rst(rst), .bus(bus));

   pot_scan_ctrl #(.NUM_POTS(3), .CH_OFFSET(4), .RES_W(RW), .AVG_SHIFT(SHIFT),
                   .HYST(HYST), .SETTLE_SCANS(SETTLE), .TIMEOUT(TMO))
      dut2 (.clk(clk), .rst(rst), .bus(bus2));

   typedef struct {
      logic [NP*RW-1:0] vals;
      logic [NP-1:0]    chg;
      logic             sd;
      logic             st;
      logic             err;
   } exp_t;

   exp_t sb[$];
   int   n_assert = 0;
   int   n_fail   = 0;
   int   m_filt [NP];
   int   m_pv   [NP];
   bit   m_first[NP];
   int   m_idx;
   int   m_scans;
   bit   m_err;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NP; i++) begin
         m_filt[i]  = 0;
         m_pv[i]    = 0;
         m_first[i] = 1'b1;
      end
      m_idx   = 0;
      m_scans = 0;
      m_err   = 1'b0;
      sb.delete();
   endtask

   function automatic logic [NP*RW-1:0] model_bus();
      logic [NP*RW-1:0] v;
      v = '0;
      for (int i = 0; i < NP; i++) v[i*RW +: RW] = RW'(m_pv[i]);
      return v;
   endfunction

   // Reference: integer floor-division smoother and deadband publish
   task automatic model_step(input int r);
      int   i, d, q, f, gap;
      bit   pub;
      exp_t e;
      i = m_idx;
      if (m_first[i]) begin
         f = r;
         pub = 1'b1;
         m_first[i] = 1'b0;
      end else begin
         d = r - m_filt[i];
         if (d >= 0) q = d / (1 << SHIFT);
         else        q = -((-d + (1 << SHIFT) - 1) / (1 << SHIFT));
         f = m_filt[i] + q;
         gap = (f > m_pv[i]) ? f - m_pv[i] : m_pv[i] - f;
         pub = (gap >= HYST) || (f == 0 && m_pv[i] != 0) || (f == 4095 && m_pv[i] != 4095);
      end
      m_filt[i] = f;
      e.chg = '0;
      if (pub) begin
         m_pv[i]  = f;
         e.chg[i] = 1'b1;
      end
      e.sd = (i == NP - 1);
      if (e.sd && m_scans < SETTLE) m_scans++;
      e.st   = (m_scans >= SETTLE);
      e.err  = m_err;
      m_idx  = (i + 1) % NP;
      e.vals = model_bus();
      sb.push_back(e);
   endtask

   task automatic wait_strt(input int limit, output int waited);
      waited = 0;
      while (bus.strt_cnv !== 1'b1 && waited < limit) begin
         @(negedge clk);
         waited++;
      end
   endtask

   // One A2D conversion answered dly cycles into WAIT; optionally drop en mid-WAIT
   task automatic conv(input int r, input int dly, input bit drop_en);
      int   w;
      exp_t e;
      wait_strt(64, w);
      chk("strt_cnv_seen", bus.strt_cnv, 1);
      chk("chnnl", bus.chnnl, m_idx);
      @(negedge clk);
      if (drop_en) bus.en = 1'b0;
      repeat (dly - 1) @(negedge clk);
      bus.res = RW'(r);
      bus.cnv_cmplt = 1'b1;
      model_step(r);
      @(negedge clk);
      bus.cnv_cmplt = 1'b0;
      chk("pot_chg_early", bus.pot_chg, 0);
      @(negedge clk);
      e = sb.pop_front();
      chk("pot_vals",  bus.pot_vals,  e.vals);
      chk("pot_chg",   bus.pot_chg,   e.chg);
      chk("scan_done", bus.scan_done, e.sd);
      chk("settled",   bus.settled,   e.st);
      chk("a2d_err",   bus.a2d_err,   e.err);
      chk("strt_next", bus.strt_cnv,  !drop_en);
   endtask

   task automatic scan(input int r0, input int r2, input int rx);
      for (int k = 0; k < NP; k++) begin
         int r;
         r = (m_idx == 0) ? r0 : (m_idx == 2) ? r2 : rx;
         conv(r, (k % 3) + 1, 1'b0);
      end
   endtask

   initial begin
      int   w, cnt, s;
      logic err_before;

      rst = 1'b1;
      bus.en = 1'b0;  bus.cnv_cmplt = 1'b0;  bus.res = '0;
      bus2.en = 1'b0; bus2.cnv_cmplt = 1'b0; bus2.res = '0;
      model_reset();
      repeat (3) @(negedge clk);
      chk("rst_strt_cnv",  bus.strt_cnv,  0);
      chk("rst_chnnl",     bus.chnnl,     0);
      chk("rst_pot_vals",  bus.pot_vals,  0);
      chk("rst_pot_chg",   bus.pot_chg,   0);
      chk("rst_scan_done", bus.scan_done, 0);
      chk("rst_settled",   bus.settled,   0);
      chk("rst_a2d_err",   bus.a2d_err,   0);
      chk("rst2_chnnl",    bus2.chnnl,    4);
      rst = 1'b0;
      @(negedge clk);
      bus.en = 1'b1;

      // First scan publishes every pot; scans 2..4 quiet; settled with 4th scan_done
      scan(12'h800, 12'h800, 12'h800);
      for (int k = 0; k < 3; k++) scan(12'h800, 12'h800, 12'h800);

      // Pot 2 step to 0xC00 and convergence
      for (int k = 0; k < 14; k++) scan(12'h800, 12'hC00, 12'h800);

      // Small move inside deadband, then full-scale up and down
      scan(12'h804, 12'hC00, 12'h800);
      for (int k = 0; k < 14; k++) scan(12'hFFF, 12'hC00, 12'h800);
      for (int k = 0; k < 36; k++) scan(12'h000, 12'hC00, 12'h800);
      chk("pot0_floor", bus.pot_vals[RW-1:0], 0);

      // Conversion timeout and retry on the same channel
      wait_strt(64, w);
      chk("tmo_strt_seen", bus.strt_cnv, 1);
      cnt = 0;
      err_before = 1'b1;
      do begin
         @(negedge clk);
         cnt++;
         if (cnt == TMO) err_before = bus.a2d_err;
      end while (bus.strt_cnv !== 1'b1 && cnt < 5000);
      chk("tmo_cycles",   cnt,         TMO + 1);
      chk("tmo_err_pre",  err_before,  0);
      chk("tmo_a2d_err",  bus.a2d_err, 1);
      chk("tmo_retry_ch", bus.chnnl,   m_idx);
      m_err = 1'b1;
      conv(12'h000, 2, 1'b0);
      conv(12'h800, 1, 1'b0);

      // en low while waiting: conversion completes, then idle
      conv(12'h800, 2, 1'b1);
      s = 0;
      repeat (20) begin
         @(negedge clk);
         if (bus.strt_cnv) s++;
      end
      chk("idle_no_strt", s, 0);
      bus.en = 1'b1;
      conv(12'h800, 1, 1'b0);

      // Reset in the middle of WAIT, then a stale completion
      wait_strt(64, w);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mid_rst_strt",     bus.strt_cnv,  0);
      chk("mid_rst_pot_vals", bus.pot_vals,  0);
      chk("mid_rst_pot_chg",  bus.pot_chg,   0);
      chk("mid_rst_settled",  bus.settled,   0);
      chk("mid_rst_a2d_err",  bus.a2d_err,   0);
      chk("mid_rst_chnnl",    bus.chnnl,     0);
      bus.en = 1'b0;
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      bus.res = 12'hABC;
      bus.cnv_cmplt = 1'b1;
      @(negedge clk);
      bus.cnv_cmplt = 1'b0;
      @(negedge clk);
      chk("late_cmplt_vals", bus.pot_vals, 0);
      chk("late_cmplt_chg",  bus.pot_chg,  0);
      chk("late_cmplt_strt", bus.strt_cnv, 0);
      bus.en = 1'b1;
      conv(12'h123, 1, 1'b0);
      bus.en = 1'b0;

      // Second instance: 3 pots starting at channel 4
      bus2.en = 1'b1;
      for (int k = 0; k < 4; k++) begin
         w = 0;
         while (bus2.strt_cnv !== 1'b1 && w < 64) begin
            @(negedge clk);
            w++;
         end
         chk("i2_strt_seen", bus2.strt_cnv, 1);
         chk("i2_chnnl", bus2.chnnl, 4 + (k % 3));
         @(negedge clk);
         bus2.res = RW'((k + 1) * 256);
         bus2.cnv_cmplt = 1'b1;
         @(negedge clk);
         bus2.cnv_cmplt = 1'b0;
         @(negedge clk);
         chk("i2_scan_done", bus2.scan_done, (k == 2));
         chk("i2_pot_chg",   bus2.pot_chg,   3'b001 << (k % 3));
      end
      bus2.en = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
